iter_div: RTL and testbench

ITER_DIV -- requirements
Module: iter_div

---
 rtl/iter_div_pkg.sv | 15 +
 rtl/iter_div.sv | 117 +++++++++++
 tb/tb_iter_div.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/iter_div_pkg.sv
// Shared CPU definitions for the iterative divider: controller state encoding
// and the number of radix-2 steps per division.
package iter_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   localparam int DIV_ITER = 32;
   localparam int CNT_W    = $clog2(DIV_ITER);

endpackage

// File: rtl/iter_div.sv
// Multi-cycle signed/unsigned divider: one restoring radix-2 step per cycle on
// operand magnitudes, followed by a sign-fixup cycle and a one-cycle done pulse.
module iter_div
   import iter_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_zero,
   output div_state_e       dbg_state
);

   // Handshake: start is taken only in IDLE with cancel low; done is a single-cycle
   // pulse and q/r/div_zero hold until the next completion.
   div_state_e       state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem, quo, dvs;
   logic             neg_q, neg_r;
   logic             accept;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   trial;

   assign accept = (state == IDLE) && start && !cancel;

   // Unary minus on an unsigned vector keeps 0x80000000 as an unsigned magnitude.
   assign a_mag = (sign && a[WIDTH-1]) ? -a : a;
   assign b_mag = (sign && b[WIDTH-1]) ? -b : b;

   // quo shifts the dividend out at the top while quotient bits enter at the bottom.
   assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

   assign busy      = (state != IDLE);
   assign done      = (state == DONE) && !cancel;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = (b == '0) ? DONE : CALC;
         CALC: begin
            if (cancel)                              state_nx = IDLE;
            else if (cnt == CNT_W'(DIV_ITER - 1))   state_nx = FIX;
         end
         FIX:     state_nx = cancel ? IDLE : DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         q        <= '0;
         r        <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt   <= '0;
                  rem   <= '0;
                  quo   <= a_mag;
                  dvs   <= b_mag;
                  neg_q <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r <= sign && a[WIDTH-1];
                  if (b == '0) begin
                     q        <= '1;
                     r        <= a;
                     div_zero <= 1'b1;
                  end
               end
            end
            CALC: begin
               if (!cancel) begin
                  cnt <= cnt + CNT_W'(1);
                  if (!trial[WIDTH]) begin
                     rem <= trial[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b1};
                  end else begin
                     rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                     quo <= {quo[WIDTH-2:0], 1'b0};
                  end
               end
            end
            FIX: begin
               if (!cancel) begin
                  q        <= neg_q ? -quo : quo;
                  r        <= neg_r ? -rem : rem;
                  div_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_div.sv
// Bench for iter_div: arithmetic reference model with a per-cycle compare
// process on busy/done/q/r/div_zero, directed corner cases and random operands.
module tb_iter_div;
   import iter_div_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         start = 1'b0;
   logic         sign = 1'b0;
   logic         cancel = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, div_zero;
   logic [W-1:0] q, r;
   div_state_e   dbg_state;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference state: the operation in flight and the values the outputs must hold.
   bit           op_active = 1'b0;
   int           op_done_cyc = 0;
   logic [W-1:0] op_q, op_r;
   logic         op_dz;
   logic [W-1:0] held_q = '0;
   logic [W-1:0] held_r = '0;
   logic         held_dz = 1'b0;

   iter_div #(.WIDTH(W)) dut (
      .clk(clk), .resetn(resetn), .start(start), .sign(sign), .a(a), .b(b),
      .cancel(cancel), .busy(busy), .done(done), .q(q), .r(r),
      .div_zero(div_zero), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Quotient truncates toward zero, remainder takes the dividend's sign.
   function automatic void model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] mq, output logic [W-1:0] mr,
                                 output logic mz);
      longint lx, ly;
      if (y == '0) begin
         mq = '1;
         mr = x;
         mz = 1'b1;
      end else begin
         lx = s ? longint'($signed(x)) : longint'({32'b0, x});
         ly = s ? longint'($signed(y)) : longint'({32'b0, y});
         mq = 32'(lx / ly);
         mr = 32'(lx % ly);
         mz = 1'b0;
      end
   endfunction

   always @(negedge clk) begin
      if (resetn) begin
         logic exp_done;
         exp_done = op_active && (cyc == op_done_cyc);
         chk("busy", {31'b0, busy}, {31'b0, op_active});
         chk("done", {31'b0, done}, {31'b0, exp_done});
         if (exp_done) begin
            held_q    = op_q;
            held_r    = op_r;
            held_dz   = op_dz;
            op_active = 1'b0;
         end
         chk("q", q, held_q);
         chk("r", r, held_r);
         chk("div_zero", {31'b0, div_zero}, {31'b0, held_dz});
      end
   end

   // Drives one request; the accepting edge is the next rising edge.
   task automatic issue(input bit now, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      if (!now) begin
         @(negedge clk);
         #1;
      end
      start = 1'b1;
      sign  = s;
      a     = x;
      b     = y;
      model(s, x, y, op_q, op_r, op_dz);
      op_done_cyc = cyc + 1 + ((y == '0) ? 0 : 33);
      op_active   = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic finish_op();
      int n = 0;
      while (op_active && n < 60) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
   endtask

   task automatic run(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      issue(1'b0, s, x, y);
      finish_op();
   endtask

   task automatic pin(input string name, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
      logic [W-1:0] mq, mr;
      logic         mz;
      model(s, x, y, mq, mr, mz);
      chk({name, "_q"}, mq, eq);
      chk({name, "_r"}, mr, er);
      chk({name, "_dz"}, {31'b0, mz}, {31'b0, ez});
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rs;

      pin("m100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      pin("mneg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      pin("m7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
      pin("mmin_neg1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      pin("mmax_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
      pin("mdz", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1);

      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_q", q, 32'd0);
      chk("rst_r", r, 32'd0);
      chk("rst_dz", {31'b0, div_zero}, 32'd0);

      // Release reset and request in the same cycle: the first edge accepts.
      #1;
      resetn = 1'b1;
      issue(1'b1, 1'b0, 32'd100, 32'd7);
      finish_op();
      run(1'b1, 32'hFFFF_FFF9, 32'd2);
      run(1'b1, 32'd7, 32'hFFFF_FFFE);
      run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run(1'b0, 32'hFFFF_FFFF, 32'd1);
      run(1'b0, 32'h1234, 32'd0);
      run(1'b0, 32'd9, 32'd3);

      // Start while busy must not disturb the operation in flight.
      issue(1'b0, 1'b0, 32'd1000, 32'd13);
      repeat (4) @(negedge clk);
      #1;
      start = 1'b1; sign = 1'b1; a = 32'hDEAD_BEEF; b = 32'd0;
      @(negedge clk);
      #1;
      start = 1'b0;
      finish_op();

      // Cancel during CALC, then a new request in the very next cycle.
      issue(1'b0, 1'b0, 32'd5000, 32'd7);
      repeat (9) @(negedge clk);
      #1;
      cancel    = 1'b1;
      op_active = 1'b0;
      @(negedge clk);
      #1;
      cancel = 1'b0;
      issue(1'b1, 1'b1, 32'hFFFF_FC18, 32'd33);
      finish_op();

      // Cancel and start together in IDLE: nothing is accepted.
      @(negedge clk);
      #1;
      cancel = 1'b1; start = 1'b1; a = 32'd50; b = 32'd5;
      @(negedge clk);
      #1;
      cancel = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);

      // Reset mid-operation clears everything at once; no done follows.
      issue(1'b0, 1'b0, 32'd77777, 32'd11);
      repeat (19) @(negedge clk);
      #1;
      resetn    = 1'b0;
      op_active = 1'b0;
      held_q    = '0;
      held_r    = '0;
      held_dz   = 1'b0;
      #1;
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_q", q, 32'd0);
      chk("midrst_r", r, 32'd0);
      chk("midrst_dz", {31'b0, div_zero}, 32'd0);
      @(negedge clk);
      #1;
      resetn = 1'b1;
      repeat (40) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = '0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 20));
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         run(rs, ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
